// File: rtl/down_counter_pkg.sv
// Shared state encoding and default width for the loadable down-counter/timer.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_if.sv
// Control, load handshake and status bundle between a controller and down_counter.
interface down_counter_if
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             clear;
    logic             enable;
    logic             load_valid;
    logic [WIDTH-1:0] load_value;
    logic             load_ready;
    logic [WIDTH-1:0] counter_out;
    logic             busy;
    logic             done;

    modport master (
        output clear, enable, load_valid, load_value,
        input  load_ready, counter_out, busy, done
    );

    modport slave (
        input  clear, enable, load_valid, load_value,
        output load_ready, counter_out, busy, done
    );

endinterface

// File: rtl/down_counter.sv
// Purpose: loadable down-counter/timer with a one-cycle registered done pulse; DOWN_COUNTER_AUTO_RELOAD_EN adds periodic reload.
// Latency: load N>0 with enable held high gives done in the cycle after the N-th edge following the accept edge.
// Backpressure: load_ready is high only in IDLE; load_valid at any other time is dropped, not queued.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    down_counter_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             load_acc;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    assign load_acc = bus.load_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_acc) begin
                        cnt_d = bus.load_value;
                        if (bus.load_value == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.enable) begin
                        if (cnt_q == WIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                            // Terminal edge restarts the period instead of showing zero.
                            cnt_d  = reload_q;
`else
                            cnt_d   = '0;
                            state_d = DONE;
`endif
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else if (load_acc && !bus.clear) begin
            reload_q <= bus.load_value;
        end
    end
`endif

    assign bus.load_ready  = (state_q == IDLE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.counter_out = cnt_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: reset, single-shot/gated counting, zero load, clear, ignored loads, auto-reload.
module tb_down_counter;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;
    logic seen_done;

    down_counter_if #(.WIDTH(4)) bus ();

    down_counter #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] cnt, input logic bsy,
                             input logic dn, input logic rdy);
        check({tag, ".cnt"},  32'(bus.counter_out), 32'(cnt));
        check({tag, ".busy"}, 32'(bus.busy),        32'(bsy));
        check({tag, ".done"}, 32'(bus.done),        32'(dn));
        check({tag, ".rdy"},  32'(bus.load_ready),  32'(rdy));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        bus.load_valid = 1'b1;
        bus.load_value = v;
        tick();
        bus.load_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1'b0;
        bus.clear = 1'b0;
        bus.enable = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_value = 4'd0;
        #12;
        check_all("reset", 4'd0, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        tick();
        check_all("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        bus.enable = 1'b1;
        load(4'd2);
        check_all("ar.accept", 4'd2, 1'b1, 1'b0, 1'b0);
        tick(); check_all("ar.e1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); check_all("ar.e2", 4'd2, 1'b1, 1'b1, 1'b0);
        tick(); check_all("ar.e3", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); check_all("ar.e4", 4'd2, 1'b1, 1'b1, 1'b0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_all("ar.clear", 4'd0, 1'b0, 1'b0, 1'b1);
`else
        // Basic: 4,3,2,1,0 with done on the 4th edge after accept.
        bus.enable = 1'b1;
        load(4'd4);
        check_all("basic.accept", 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 1; i--) begin
            tick();
            check_all("basic.dec", 4'(i), 1'b1, 1'b0, 1'b0);
        end
        tick(); check_all("basic.done", 4'd0, 1'b1, 1'b1, 1'b0);
        tick(); check_all("basic.idle", 4'd0, 1'b0, 1'b0, 1'b1);

        // Gated: enable low for two cycles after the first decrement.
        load(4'd3);
        check_all("gate.accept", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); check_all("gate.e1", 4'd2, 1'b1, 1'b0, 1'b0);
        bus.enable = 1'b0;
        tick(); check_all("gate.hold1", 4'd2, 1'b1, 1'b0, 1'b0);
        tick(); check_all("gate.hold2", 4'd2, 1'b1, 1'b0, 1'b0);
        bus.enable = 1'b1;
        tick(); check_all("gate.e4", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); check_all("gate.done", 4'd0, 1'b1, 1'b1, 1'b0);
        tick(); check_all("gate.idle", 4'd0, 1'b0, 1'b0, 1'b1);
`endif

        // Zero load: straight to a single DONE cycle, then IDLE.
        bus.enable = 1'b1;
        load(4'd0);
        check_all("zero.done", 4'd0, 1'b1, 1'b1, 1'b0);
        tick(); check_all("zero.idle", 4'd0, 1'b0, 1'b0, 1'b1);

        // Full-scale load value is accepted and decrements normally.
        load(4'd15);
        check_all("max.accept", 4'd15, 1'b1, 1'b0, 1'b0);
        tick(); check_all("max.e1", 4'd14, 1'b1, 1'b0, 1'b0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_all("max.clear", 4'd0, 1'b0, 1'b0, 1'b1);

        // Load during RUN ignored; clear with simultaneous load_valid wins.
        load(4'd9);
        tick(); tick();
        check_all("ign.at7", 4'd7, 1'b1, 1'b0, 1'b0);
        load(4'd1);
        check_all("ign.after", 4'd6, 1'b1, 1'b0, 1'b0);
        for (int i = 5; i >= 2; i--) tick();
        check_all("clr.at2", 4'd2, 1'b1, 1'b0, 1'b0);
        bus.clear = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_value = 4'd5;
        tick();
        bus.clear = 1'b0;
        bus.load_valid = 1'b0;
        check_all("clr.idle", 4'd0, 1'b0, 1'b0, 1'b1);
        tick(); check_all("clr.stay", 4'd0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-RUN at count 5, between edges.
        load(4'd9);
        for (int i = 0; i < 4; i++) tick();
        check_all("rst.at5", 4'd5, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_all("rst.async", 4'd0, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        check("rst.no_done", 32'(seen_done), 32'd0);
        check_all("rst.final", 4'd0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable down-counter and timer; the count-down counterpart of the team's 4-bit up counter.
- Accepts a start value through a valid/ready load handshake.
- Decrements on each clock edge where enable is high.
- Emits a one-cycle done pulse on reaching zero. Used as a programmable delay/timeout source beside the up counter.

Parameters:
- WIDTH, 4, bit width of load_value and counter_out.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; returns the block to IDLE.
- enable  input  1  count gate; a decrement occurs only on edges where enable=1.
- load_valid  input  1  load request.
- load_value  input  WIDTH  start value.
- load_ready  output  1  high when a load can be accepted.
- counter_out  output  WIDTH  current count.
- busy  output  1  high when state is not IDLE.
- done  output  1  registered one-cycle pulse when the count reaches zero.

Behaviour:
- Reset: reset low asynchronously forces the following, regardless of state:
  - state=IDLE, counter_out=0, done=0, reload register=0.
  - busy=0 and load_ready=1, since both are decoded from state.
  - Release is sampled on the next rising edge.
- States: IDLE, RUN, DONE.
- Priority per edge: clear > load accept > count.
- clear=1 in any state: next state IDLE, counter_out=0, done=0. A simultaneous load_valid is ignored.
- load_ready = (state==IDLE), combinational from state.
- Load accept: an edge with load_valid=1 and load_ready=1.
  - counter_out <= load_value.
  - If load_value != 0, next state RUN.
  - If load_value == 0, next state DONE and done <= 1.
- RUN, enable=1, counter_out > 1: counter_out decrements by 1.
- RUN, enable=1, counter_out == 1: counter_out <= 0, done <= 1, next state DONE.
- RUN, enable=0: counter_out holds and the state stays RUN.
- DONE: lasts exactly one cycle, with done=1 and counter_out=0. Next edge goes to IDLE and done <= 0; enable is ignored.
- IDLE: enable is ignored; counter_out holds its last value (0 after completion).
- load_valid outside IDLE is ignored; no queueing.
- Latency, load N>0 with enable held high: done is high in the cycle after the N-th edge following the accept edge. load_ready rises one edge later.
- Arithmetic: unsigned, no wrap. Zero is terminal, so no underflow is possible. load_value = 2^WIDTH-1 is legal.
- Reset mid-RUN aborts immediately with no done pulse.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- When defined:
  - A WIDTH-bit reload register captures load_value at each load accept.
  - In RUN, the edge that would take counter_out from 1 to 0 instead loads the reload value and pulses done; the state stays RUN.
  - Result: done is periodic with period N edges of enable=1. counter_out never shows 0 while running.
  - load_ready stays 0 until clear or reset.
  - A load of 0 behaves as single-shot: one DONE cycle, then IDLE.
- When undefined: single-shot behaviour as above; there is no reload register.

Decomposition:
- Shared package down_counter_pkg: state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2, plus the default WIDTH constant.
- No sub-module: the state machine and datapath form a single module. The reload register lives inline under the macro.

Test Plan:
- Reset: load 9, enable high; assert reset low at count 5, between edges. Immediately: counter_out=0, busy=0, done=0, load_ready=1. After release, no done pulse ever appears.
- Basic count: load 4, enable high. counter_out reads 4,3,2,1,0 on successive edges. done is high for exactly one cycle, coincident with counter_out=0, 4 edges after accept. load_ready=1 one edge later.
- Gated count: load 3; drop enable for 2 cycles after the first decrement. counter_out holds at 2 during the gap. done occurs 5 edges after accept.
- Zero load: load 0. done pulses on the next cycle, RUN is never entered, and IDLE follows one edge later.
- Clear and ignored load: at count 2, assert clear and load_valid together. Result: IDLE, counter_out=0, no done. A load_valid asserted during RUN (count 7, value 1) leaves the count unaffected.
- Auto-reload, with DOWN_COUNTER_AUTO_RELOAD_EN: load 2, enable high. counter_out reads 2,1,2,1,2 with done on every second edge. clear stops it and returns to IDLE with counter_out=0.
